// File: rtl/hpm_counter_bank.sv
`default_nettype none
// ----------------------------------------------------------------------------
// hpm_counter_bank: configurable HPM counters, multi-unit increments, CSR port
// Rev 1.0
// ----------------------------------------------------------------------------
module hpm_counter_bank #(
  parameter int unsigned NumCounters = 6,
  parameter int unsigned CntWidth    = 64,
  parameter int unsigned NumEvents   = 32,
  parameter int unsigned IncWidth    = 2,
  parameter int unsigned XLEN        = 64,
  localparam int unsigned SelWidth   = (NumCounters > 1) ? $clog2(NumCounters) : 1
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          debug_mode_i,
  input  logic [NumEvents*IncWidth-1:0] event_inc_i,
  input  logic [SelWidth-1:0]           sel_i,
  input  logic [2:0]                    field_i,
  input  logic                          we_i,
  input  logic [XLEN-1:0]               data_i,
  output logic [XLEN-1:0]               data_o,
  output logic                          access_err_o,
  output logic [NumCounters-1:0]        threshold_o,
  output logic                          ovf_irq_o
);

  localparam int unsigned EvWidth = (NumEvents > 1) ? $clog2(NumEvents) : 1;
  localparam int unsigned HiWidth = CntWidth - 32;

  logic [CntWidth-1:0]    cnt_q   [NumCounters];
  logic [CntWidth-1:0]    cnt_d   [NumCounters];
  logic [CntWidth-1:0]    thr_q   [NumCounters];
  logic [CntWidth-1:0]    thr_d   [NumCounters];
  logic [EvWidth-1:0]     evsel_q [NumCounters];
  logic [EvWidth-1:0]     evsel_d [NumCounters];
  logic [NumCounters-1:0] ovfen_q, ovfen_d, of_q, of_d, inh_q, inh_d;

  logic [IncWidth-1:0]    inc     [NumCounters];
  logic [CntWidth:0]      sum     [NumCounters];
  logic [NumCounters-1:0] wr_cnt, wr_cfg, wr_thr;

  logic        sel_ok, hi_field, field_ok, access_err;
  logic [63:0] wdata64;
  logic [63:0] rd_cnt, rd_thr, rd_cfg, rd_word;
  logic        unused_bits;

  assign wdata64 = 64'(data_i);

  // Merges a CSR write into a CntWidth register; high half only exists for XLEN=32
  function automatic logic [CntWidth-1:0] merge_word(input logic [CntWidth-1:0] old_val,
                                                     input logic                hi,
                                                     input logic [63:0]         wd);
    logic [CntWidth-1:0] r;
    r = old_val;
    if (XLEN == 64)   r = wd[CntWidth-1:0];
    else if (hi)      r[CntWidth-1:32] = wd[HiWidth-1:0];
    else              r[31:0] = wd[31:0];
    return r;
  endfunction

  always_comb begin
    sel_ok     = 32'(sel_i) < NumCounters;
    hi_field   = (field_i == 3'd1) || (field_i == 3'd4);
    field_ok   = (field_i <= 3'd4) && !(hi_field && (XLEN == 64));
    access_err = rst_ni && !(sel_ok && field_ok);
  end

  always_comb begin
    rd_cnt = '0;
    rd_thr = '0;
    rd_cfg = '0;
    for (int i = 0; i < NumCounters; i++) begin
      if (sel_i == SelWidth'(i)) begin
        rd_cnt                = 64'(cnt_q[i]);
        rd_thr                = 64'(thr_q[i]);
        rd_cfg[EvWidth-1:0]   = evsel_q[i];
        rd_cfg[13]            = ovfen_q[i];
        rd_cfg[14]            = of_q[i];
        rd_cfg[15]            = inh_q[i];
      end
    end
    case (field_i)
      3'd0:    rd_word = rd_cnt;
      3'd1:    rd_word = rd_cnt >> 32;
      3'd2:    rd_word = rd_cfg;
      3'd3:    rd_word = rd_thr;
      3'd4:    rd_word = rd_thr >> 32;
      default: rd_word = '0;
    endcase
    if (access_err) rd_word = '0;
  end

  assign data_o       = rd_word[XLEN-1:0];
  assign access_err_o = access_err;
  assign unused_bits  = ^{rd_word, wdata64};

  always_comb begin
    ovfen_d = ovfen_q;
    of_d    = of_q;
    inh_d   = inh_q;
    wr_cnt  = '0;
    wr_cfg  = '0;
    wr_thr  = '0;
    for (int i = 0; i < NumCounters; i++) begin
      wr_cnt[i] = we_i && !access_err && (sel_i == SelWidth'(i)) &&
                  ((field_i == 3'd0) || (field_i == 3'd1));
      wr_cfg[i] = we_i && !access_err && (sel_i == SelWidth'(i)) && (field_i == 3'd2);
      wr_thr[i] = we_i && !access_err && (sel_i == SelWidth'(i)) &&
                  ((field_i == 3'd3) || (field_i == 3'd4));

      inc[i] = IncWidth'(event_inc_i >> (32'(evsel_q[i]) * IncWidth));
      // A CSR write to this counter owns the cycle; its event is dropped
      if ((evsel_q[i] == '0) || (32'(evsel_q[i]) >= NumEvents) || inh_q[i] ||
          debug_mode_i || wr_cnt[i] || wr_cfg[i])
        inc[i] = '0;
      sum[i] = {1'b0, cnt_q[i]} + (CntWidth+1)'(inc[i]);

      cnt_d[i]   = sum[i][CntWidth-1:0];
      of_d[i]    = of_q[i] | sum[i][CntWidth];
      thr_d[i]   = thr_q[i];
      evsel_d[i] = evsel_q[i];

      if (wr_cfg[i]) begin
        cnt_d[i]   = '0;
        evsel_d[i] = wdata64[EvWidth-1:0];
        ovfen_d[i] = wdata64[13];
        of_d[i]    = wdata64[14];
        inh_d[i]   = wdata64[15];
      end else if (wr_cnt[i]) begin
        cnt_d[i] = merge_word(cnt_q[i], field_i == 3'd1, wdata64);
      end
      if (wr_thr[i]) thr_d[i] = merge_word(thr_q[i], field_i == 3'd4, wdata64);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NumCounters; i++) begin
        cnt_q[i]   <= '0;
        thr_q[i]   <= '0;
        evsel_q[i] <= '0;
      end
      ovfen_q <= '0;
      of_q    <= '0;
      inh_q   <= '0;
    end else begin
      for (int i = 0; i < NumCounters; i++) begin
        cnt_q[i]   <= cnt_d[i];
        thr_q[i]   <= thr_d[i];
        evsel_q[i] <= evsel_d[i];
      end
      ovfen_q <= ovfen_d;
      of_q    <= of_d;
      inh_q   <= inh_d;
    end
  end

  always_comb begin
    threshold_o = '0;
    for (int i = 0; i < NumCounters; i++)
      threshold_o[i] = (thr_q[i] != '0) && (cnt_q[i] >= thr_q[i]);
  end

  assign ovf_irq_o = |(of_q & ovfen_q);

endmodule
`default_nettype wire
